// File: rtl/pipe_pkg.sv
// Shared pipeline types: control bundles, ID/EX payload layout and stage states.
package pipe_pkg;

    localparam int INTERNAL_BITS = 32;
    localparam int REG_BITS      = 5;
    localparam int EX_W          = 4;
    localparam int M_W           = 3;
    localparam int WB_W          = 2;

    typedef struct packed {
        logic       reg_dst;
        logic [1:0] alu_op;
        logic       alu_src;
    } ex_ctrl_t;

    typedef struct packed {
        logic branch;
        logic mem_read;
        logic mem_write;
    } m_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    typedef struct packed {
        ex_ctrl_t                 ex;
        m_ctrl_t                  m;
        wb_ctrl_t                 wb;
        logic [INTERNAL_BITS-1:0] rd1;
        logic [INTERNAL_BITS-1:0] rd2;
        logic [INTERNAL_BITS-1:0] imm;
        logic [INTERNAL_BITS-1:0] pc;
        logic [REG_BITS-1:0]      rt;
        logic [REG_BITS-1:0]      rd;
    } id_ex_payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Skid entry: parks one payload word while the main stage register is stalled.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID->EX stage register with valid/ready handshake, flush-to-bubble and control masking.
// Define ID_EX_SKID_EN to add a registered-ready skid entry (EMPTY/FULL/SKID).
module id_ex_pipe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = INTERNAL_BITS,
    parameter int REG_W  = REG_BITS,
    parameter int EX_W   = pipe_pkg::EX_W,
    parameter int M_W    = pipe_pkg::M_W,
    parameter int WB_W   = pipe_pkg::WB_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [EX_W-1:0]   ex_in,
    input  logic [M_W-1:0]    m_in,
    input  logic [WB_W-1:0]   wb_in,
    input  logic [DATA_W-1:0] rd1_in,
    input  logic [DATA_W-1:0] rd2_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [REG_W-1:0]  rt_in,
    input  logic [REG_W-1:0]  rd_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EX_W-1:0]   ex_out,
    output logic [M_W-1:0]    m_out,
    output logic [WB_W-1:0]   wb_out,
    output logic [DATA_W-1:0] rd1_out,
    output logic [DATA_W-1:0] rd2_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [REG_W-1:0]  rt_out,
    output logic [REG_W-1:0]  rd_out
);

    // Same field order as id_ex_payload_t, sized by this instance's parameters.
    typedef struct packed {
        logic [EX_W-1:0]   ex;
        logic [M_W-1:0]    m;
        logic [WB_W-1:0]   wb;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
    } payload_t;

    pipe_state_t state_q, state_d;
    payload_t    in_word, main_d, main_q;
    logic        accept, transfer, main_load;

    assign in_word = '{ex: ex_in, m: m_in, wb: wb_in, rd1: rd1_in, rd2: rd2_in,
                       imm: imm_in, pc: pc_in, rt: rt_in, rd: rd_in};

    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign transfer  = out_valid & out_ready;

`ifdef ID_EX_SKID_EN
    logic     in_ready_q, skid_load, main_from_skid;
    payload_t skid_word;

    pipe_skid_buf #(.W($bits(payload_t))) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .d     (in_word),
        .q     (skid_word)
    );

    // Ready is a flop so decode never sees a combinational path from out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (state_d != SKID);
        end
    end

    assign in_ready = in_ready_q;
    assign main_d   = main_from_skid ? skid_word : in_word;
`else
    assign in_ready = out_ready | ~out_valid;
    assign main_d   = in_word;
`endif

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
`ifdef ID_EX_SKID_EN
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
`endif
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d   = FULL;
                    main_load = 1'b1;
                end
            end
            FULL: begin
                if (transfer && accept) begin
                    main_load = 1'b1;
                end else if (transfer) begin
                    state_d = EMPTY;
`ifdef ID_EX_SKID_EN
                end else if (accept) begin
                    state_d   = SKID;
                    skid_load = 1'b1;
`endif
                end
            end
`ifdef ID_EX_SKID_EN
            SKID: begin
                if (transfer) begin
                    state_d        = FULL;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
`endif
            default: state_d = EMPTY;
        endcase

        // Flush drops held and incoming words; the main register keeps its old data.
        if (flush) begin
            state_d   = EMPTY;
            main_load = 1'b0;
`ifdef ID_EX_SKID_EN
            skid_load = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the payload register is reset too, because outputs must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
        end else if (main_load) begin
            main_q <= main_d;
        end
    end

    // Bubbles must never carry a write enable downstream.
    assign ex_out  = main_q.ex & {EX_W{out_valid}};
    assign m_out   = main_q.m  & {M_W{out_valid}};
    assign wb_out  = main_q.wb & {WB_W{out_valid}};
    assign rd1_out = main_q.rd1;
    assign rd2_out = main_q.rd2;
    assign imm_out = main_q.imm;
    assign pc_out  = main_q.pc;
    assign rt_out  = main_q.rt;
    assign rd_out  = main_q.rd;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Self-checking bench for id_ex_pipe_stage: directed plan steps then random traffic
// against a queue-based model (capacity 1, or 2 when ID_EX_SKID_EN is defined).
module tb_id_ex_pipe_stage;

    typedef struct packed {
        logic [3:0]  ex;
        logic [2:0]  m;
        logic [1:0]  wb;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } item_t;

    logic        clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready;
    logic [3:0]  ex_in, ex_out;
    logic [2:0]  m_in, m_out;
    logic [1:0]  wb_in, wb_out;
    logic [31:0] rd1_in, rd2_in, imm_in, pc_in, rd1_out, rd2_out, imm_out, pc_out;
    logic [4:0]  rt_in, rd_in, rt_out, rd_out;

    int    errors = 0;
    int    checks = 0;
    item_t q[$];
    item_t shown;

    id_ex_pipe_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .ex_in(ex_in), .m_in(m_in), .wb_in(wb_in),
        .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in), .pc_in(pc_in),
        .rt_in(rt_in), .rd_in(rd_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .ex_out(ex_out), .m_out(m_out), .wb_out(wb_out),
        .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_out(imm_out), .pc_out(pc_out),
        .rt_out(rt_out), .rd_out(rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks += 1;
        assert (obs === exp) else begin
            errors += 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic item_t rnd_item(input logic [31:0] pc);
        item_t it;
        it.ex  = 4'($urandom);
        it.m   = 3'($urandom);
        it.wb  = 2'($urandom);
        it.rd1 = $urandom;
        it.rd2 = $urandom;
        it.imm = $urandom;
        it.pc  = pc;
        it.rt  = 5'($urandom);
        it.rd  = 5'($urandom);
        return it;
    endfunction

    // Model ready: the stage can take a word when it has room after this cycle's drain.
    function automatic logic model_ready(input logic ordy);
`ifdef ID_EX_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || ordy;
`endif
    endfunction

    task automatic check_outputs(input logic ordy);
        logic  exp_v;
        item_t f;
        exp_v = q.size() > 0;
        f     = exp_v ? q[0] : '0;
        check("out_valid", 256'(out_valid), 256'(exp_v));
        check("in_ready", 256'(in_ready), 256'(model_ready(ordy)));
        check("ctrl", 256'({ex_out, m_out, wb_out}), 256'({f.ex, f.m, f.wb}));
        check("pc_out", 256'(pc_out), 256'(shown.pc));
        check("data", 256'({rd1_out, rd2_out, imm_out, rt_out, rd_out}),
              256'({shown.rd1, shown.rd2, shown.imm, shown.rt, shown.rd}));
    endtask

    // One clock cycle: drive at negedge, check, then advance the model at posedge.
    task automatic cyc(input logic v, input item_t it, input logic ordy, input logic fl);
        logic rdy, acc, xfer;
        @(negedge clk);
        in_valid  = v;
        out_ready = ordy;
        flush     = fl;
        {ex_in, m_in, wb_in, rd1_in, rd2_in, imm_in, pc_in, rt_in, rd_in} = it;
        #1;
        check_outputs(ordy);
        rdy  = model_ready(ordy);
        acc  = v && rdy;
        xfer = (q.size() > 0) && ordy;
        @(posedge clk);
        if (!rst_n || fl) begin
            q.delete();
            if (!rst_n) shown = '0;
        end else begin
            if (xfer) void'(q.pop_front());
            if (acc) q.push_back(it);
            if (q.size() > 0) shown = q[0];
        end
    endtask

    task automatic async_reset_check();
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_in_ready", 256'(in_ready), 256'(1));
        check("rst_ctrl", 256'({ex_out, m_out, wb_out}), 256'(0));
        check("rst_data", 256'({rd1_out, rd2_out, imm_out, pc_out, rt_out, rd_out}), 256'(0));
    endtask

    initial begin
        item_t it;
        shown = '0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        flush = 1'b0;
        {ex_in, m_in, wb_in, rd1_in, rd2_in, imm_in, pc_in, rt_in, rd_in} = '0;

        // Reset held with an offered instruction: nothing captured.
        for (int i = 0; i < 3; i++) cyc(1'b1, rnd_item(32'h40), 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Streaming at full rate.
        cyc(1'b1, rnd_item(32'h00), 1'b1, 1'b0);
        cyc(1'b1, rnd_item(32'h04), 1'b1, 1'b0);
        cyc(1'b1, rnd_item(32'h08), 1'b1, 1'b0);
        cyc(1'b0, rnd_item(32'h0c), 1'b1, 1'b0);

        // Stall with 0x10 held, 0x14 offered behind it, then release.
        cyc(1'b1, rnd_item(32'h10), 1'b1, 1'b0);
        cyc(1'b1, rnd_item(32'h14), 1'b0, 1'b0);
        cyc(1'b1, rnd_item(32'h18), 1'b0, 1'b0);
        cyc(1'b1, rnd_item(32'h18), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, rnd_item(32'h1c), 1'b1, 1'b0);

        // Flush while FULL with live write controls and a new offer.
        it    = rnd_item(32'h20);
        it.wb = 2'b10;
        it.m  = 3'b001;
        cyc(1'b1, it, 1'b0, 1'b0);
        cyc(1'b1, rnd_item(32'h24), 1'b0, 1'b1);
        cyc(1'b0, rnd_item(32'h28), 1'b1, 1'b0);
        cyc(1'b0, rnd_item(32'h28), 1'b1, 1'b0);

        // Bubble gap between two instructions.
        cyc(1'b1, rnd_item(32'h30), 1'b1, 1'b0);
        cyc(1'b0, rnd_item(32'h34), 1'b1, 1'b0);
        cyc(1'b0, rnd_item(32'h34), 1'b1, 1'b0);
        cyc(1'b1, rnd_item(32'h38), 1'b1, 1'b0);
        cyc(1'b0, rnd_item(32'h3c), 1'b1, 1'b0);

        // Fill the stage (SKID in skid mode), then assert reset between edges.
        cyc(1'b1, rnd_item(32'h100), 1'b0, 1'b0);
        cyc(1'b1, rnd_item(32'h104), 1'b0, 1'b0);
        cyc(1'b1, rnd_item(32'h108), 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        shown = '0;
        async_reset_check();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, rnd_item(32'h10c), 1'b1, 1'b0);

        // Random traffic with back-pressure and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, rnd_item($urandom),
                $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end

        // Drain and confirm the stage empties.
        for (int i = 0; i < 3; i++) cyc(1'b0, rnd_item(32'h0), 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
